// File: rtl/pe_array_cfg_ctrl.sv
// PE array configuration sequencer: row tags, ID tags, then PE/LN info strobes.
// Optional watchdog on the tag stream when CFG_TIMEOUT_EN is defined.
module pe_array_cfg_ctrl #(
    parameter int XBUS_NUMS      = 12,
    parameter int PE_NUMS        = 14,
    parameter int ID_LEN         = 5,
    parameter int ROW_LEN        = 4,
    parameter int NET_NUMS       = 4,
    parameter int PE_CFG_W       = 39,
    parameter int CFG_W          = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PE_CFG_W-1:0]  pe_cfg_word,
    input  logic [XBUS_NUMS-1:0] ln_cfg_word,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CFG_W-1:0]     cfg_data,
    output logic                 set_row,
    output logic [ROW_LEN-1:0]   row_scan_in,
    output logic                 set_id,
    output logic [ID_LEN-1:0]    id_scan_in,
    output logic                 set_pe_info,
    output logic [PE_CFG_W-1:0]  pe_config_in,
    output logic                 set_ln_info,
    output logic [XBUS_NUMS-1:0] LN_config_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int ROW_CNT = NET_NUMS * XBUS_NUMS;
    localparam int ID_CNT  = NET_NUMS * XBUS_NUMS * PE_NUMS;
    localparam int CNT_W   = $clog2(ID_CNT + 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW_CNT - 1);
    localparam logic [CNT_W-1:0] ID_LAST  = CNT_W'(ID_CNT - 1);

    if (CFG_W < ROW_LEN || CFG_W < ID_LEN || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("pe_array_cfg_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        ROW_SHIFT,
        ID_SHIFT,
        PE_CFG,
        LN_CFG,
        DONE_ST
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nx;
    logic [PE_CFG_W-1:0]  pe_word_q;
    logic [XBUS_NUMS-1:0] ln_word_q;
    logic                 shifting;
    logic                 hs;
    logic                 timeout;

    assign shifting  = (state == ROW_SHIFT) || (state == ID_SHIFT);
    assign cfg_ready = shifting;
    assign hs        = cfg_valid && cfg_ready;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE_ST);

`ifdef CFG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;

    // Counts consecutive handshake-free shift cycles; a handshake always wins.
    always_ff @(posedge clk) begin
        if (rst || !shifting || hs) begin
            wd <= '0;
        end else begin
            wd <= wd + WD_W'(1);
        end
    end

    assign timeout = shifting && !hs && (wd == WD_LAST);
    assign err     = timeout;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ROW_SHIFT;
                    cnt_nx   = '0;
                end
            end
            ROW_SHIFT: begin
                if (hs) begin
                    if (cnt == ROW_LAST) begin
                        state_nx = ID_SHIFT;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            ID_SHIFT: begin
                if (hs) begin
                    if (cnt == ID_LAST) begin
                        state_nx = PE_CFG;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end else if (timeout) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            end
            PE_CFG:  state_nx = LN_CFG;
            LN_CFG:  state_nx = DONE_ST;
            DONE_ST: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pe_word_q    <= '0;
            ln_word_q    <= '0;
            set_row      <= 1'b0;
            row_scan_in  <= '0;
            set_id       <= 1'b0;
            id_scan_in   <= '0;
            set_pe_info  <= 1'b0;
            pe_config_in <= '0;
            set_ln_info  <= 1'b0;
            LN_config_in <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            set_row     <= hs && (state == ROW_SHIFT);
            set_id      <= hs && (state == ID_SHIFT);
            set_pe_info <= (state == PE_CFG);
            set_ln_info <= (state == LN_CFG);
            if (state == IDLE && start) begin
                pe_word_q <= pe_cfg_word;
                ln_word_q <= ln_cfg_word;
            end
            // Scan data holds its last value between shifts.
            if (hs && state == ROW_SHIFT) begin
                row_scan_in <= cfg_data[ROW_LEN-1:0];
            end
            if (hs && state == ID_SHIFT) begin
                id_scan_in <= cfg_data[ID_LEN-1:0];
            end
            if (state == PE_CFG) begin
                pe_config_in <= pe_word_q;
            end
            if (state == LN_CFG) begin
                LN_config_in <= ln_word_q;
            end
        end
    end

endmodule

// File: tb/tb_pe_array_cfg_ctrl.sv
// Randomized self-checking bench for pe_array_cfg_ctrl (XBUS_NUMS=2, PE_NUMS=3).
// Timeout expectations follow CFG_TIMEOUT_EN when it is defined.
module tb_pe_array_cfg_ctrl;

    localparam int XB    = 2;
    localparam int PN    = 3;
    localparam int NROW  = 4 * XB;
    localparam int NID   = 4 * XB * PN;
    localparam int NTAG  = NROW + NID;
    localparam int TOUT  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [38:0] pe_cfg_word = '0;
    logic [1:0]  ln_cfg_word = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [4:0]  cfg_data = '0;
    logic        set_row;
    logic [3:0]  row_scan_in;
    logic        set_id;
    logic [4:0]  id_scan_in;
    logic        set_pe_info;
    logic [38:0] pe_config_in;
    logic        set_ln_info;
    logic [1:0]  LN_config_in;
    logic        busy;
    logic        done;
    logic        err;

    pe_array_cfg_ctrl #(
        .XBUS_NUMS(XB), .PE_NUMS(PN), .ID_LEN(5), .ROW_LEN(4),
        .NET_NUMS(4), .PE_CFG_W(39), .CFG_W(5), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .pe_cfg_word(pe_cfg_word), .ln_cfg_word(ln_cfg_word),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .set_row(set_row), .row_scan_in(row_scan_in),
        .set_id(set_id), .id_scan_in(id_scan_in),
        .set_pe_info(set_pe_info), .pe_config_in(pe_config_in),
        .set_ln_info(set_ln_info), .LN_config_in(LN_config_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [57:0] all_out;
    assign all_out = {cfg_ready, set_row, row_scan_in, set_id, id_scan_in,
                      set_pe_info, pe_config_in, set_ln_info, LN_config_in,
                      busy, done, err};

    int checks = 0;
    int failures = 0;

    logic [4:0]  src[$];
    logic [3:0]  obs_row[$];
    logic [4:0]  obs_id[$];
    logic [38:0] obs_pe;
    logic [1:0]  obs_ln;
    int cyc = 0;
    int n_pe, n_ln, n_done, n_err, n_busy, n_overlap, n_strobe_bad;
    int pe_cyc, ln_cyc, done_cyc, err_cyc, last_id_cyc, last_hs_cyc;
    bit prev_hs;

    // Observation only: records what the array would see each cycle.
    always @(negedge clk) begin
        cyc++;
        if (set_row) obs_row.push_back(row_scan_in);
        if (set_id) begin
            obs_id.push_back(id_scan_in);
            last_id_cyc = cyc;
        end
        if (int'(set_row) + int'(set_id) + int'(set_pe_info) + int'(set_ln_info) > 1)
            n_overlap++;
        if ((set_row | set_id) !== prev_hs) n_strobe_bad++;
        prev_hs = cfg_valid & cfg_ready;
        if (cfg_valid & cfg_ready) last_hs_cyc = cyc;
        if (set_pe_info) begin n_pe++; pe_cyc = cyc; obs_pe = pe_config_in; end
        if (set_ln_info) begin n_ln++; ln_cyc = cyc; obs_ln = LN_config_in; end
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (busy) n_busy++;
    end

    task automatic clear_mon();
        obs_row.delete();
        obs_id.delete();
        n_pe = 0; n_ln = 0; n_done = 0; n_err = 0; n_busy = 0;
        n_overlap = 0; n_strobe_bad = 0; prev_hs = 0;
        pe_cyc = -1; ln_cyc = -1; done_cyc = -1; err_cyc = -1;
        last_id_cyc = -1; last_hs_cyc = -1;
        obs_pe = '0; obs_ln = '0;
    endtask

    // mode 0: 0,1,2..  mode 1: random  mode 2: rows all-ones, ids random
    task automatic make_src(input int mode);
        src.delete();
        for (int i = 0; i < NTAG; i++) begin
            if (mode == 0) src.push_back(5'(i));
            else if (mode == 2 && i < NROW) src.push_back(5'h1f);
            else src.push_back(5'($urandom_range(0, 31)));
        end
    endtask

    task automatic new_words();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        pe_cfg_word = r[38:0];
        ln_cfg_word = 2'($urandom_range(0, 3));
    endtask

    // vmode 0: valid always, 1: every other cycle, 2: random
    task automatic run_pass(input int vmode, input int abort_at, input int restart_at,
                            input logic [38:0] alt_word, input int stop_at,
                            input int budget);
        int  idx = 0;
        int  k = 0;
        bit  hs;
        bit  restarted = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (k < budget && n_done == 0 && n_err == 0) begin
            if (idx == abort_at) begin
                cfg_valid = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            start = 1'b0;
            if (idx == restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1;
                pe_cfg_word = alt_word;
            end
            if (vmode == 0) cfg_valid = 1'b1;
            else if (vmode == 1) cfg_valid = (k % 2 == 1);
            else cfg_valid = 1'($urandom_range(0, 1));
            if (idx >= stop_at || idx >= NTAG) cfg_valid = 1'b0;
            cfg_data = (idx < NTAG) ? src[idx] : 5'h0;
            hs = cfg_valid && cfg_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            k++;
        end
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag);
        checks++;
        if (obs_row.size() != NROW || obs_id.size() != NID) begin
            failures++;
            $display("FAIL %s_len rows=%0d ids=%0d required rows=%0d ids=%0d",
                     tag, obs_row.size(), obs_id.size(), NROW, NID);
            return;
        end
        for (int i = 0; i < NROW; i++) begin
            checks++;
            if (obs_row[i] !== src[i][3:0]) begin
                failures++;
                $display("FAIL %s_row[%0d] got=%h required=%h", tag, i, obs_row[i], src[i][3:0]);
            end
        end
        for (int i = 0; i < NID; i++) begin
            checks++;
            if (obs_id[i] !== src[NROW+i]) begin
                failures++;
                $display("FAIL %s_id[%0d] got=%h required=%h", tag, i, obs_id[i], src[NROW+i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", all_out);
        end
        clear_mon();
        cfg_valid = 1'b1;
        cfg_data = 5'h1f;
        repeat (3) @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_row.size() != 0 || n_busy != 0 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid rows=%0d busy_cycles=%0d ready=%b required 0/0/0",
                     obs_row.size(), n_busy, cfg_ready);
        end
    endtask

    task automatic test_basic_pass();
        logic [38:0] w;
        logic [1:0]  l;
        make_src(0);
        new_words();
        w = pe_cfg_word;
        l = ln_cfg_word;
        clear_mon();
        run_pass(0, -1, -1, '0, NTAG, 200);
        @(negedge clk);
        check_stream("basic");
        checks++;
        if (n_pe != 1 || obs_pe !== w) begin
            failures++;
            $display("FAIL basic_pe n=%0d got=%h required n=1 word=%h", n_pe, obs_pe, w);
        end
        checks++;
        if (n_ln != 1 || obs_ln !== l) begin
            failures++;
            $display("FAIL basic_ln n=%0d got=%h required n=1 flags=%h", n_ln, obs_ln, l);
        end
        checks++;
        if (n_done != 1 || n_err != 0 || n_overlap != 0 || n_strobe_bad != 0) begin
            failures++;
            $display("FAIL basic_ctrl done=%0d err=%0d overlap=%0d strobe_bad=%0d required 1/0/0/0",
                     n_done, n_err, n_overlap, n_strobe_bad);
        end
        checks++;
        if (pe_cyc != last_id_cyc + 1 || ln_cyc != pe_cyc + 1 || done_cyc != ln_cyc) begin
            failures++;
            $display("FAIL basic_order id=%0d pe=%0d ln=%0d done=%0d required pe=id+1 ln=pe+1 done=ln",
                     last_id_cyc, pe_cyc, ln_cyc, done_cyc);
        end
        checks++;
        if (n_busy != NTAG + 3 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy cycles=%0d now=%b required %0d/0", n_busy, busy, NTAG + 3);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (pe_config_in !== w || LN_config_in !== l) begin
            failures++;
            $display("FAIL basic_hold pe=%h ln=%h required %h/%h", pe_config_in, LN_config_in, w, l);
        end
    endtask

    task automatic test_stall();
        for (int m = 1; m <= 2; m++) begin
            make_src(1);
            new_words();
            clear_mon();
            run_pass(m, -1, -1, '0, NTAG, 400);
            @(negedge clk);
            check_stream(m == 1 ? "stall_alt" : "stall_rand");
            checks++;
            if (n_done != 1 || n_strobe_bad != 0 || n_overlap != 0) begin
                failures++;
                $display("FAIL stall_ctrl mode=%0d done=%0d strobe_bad=%0d overlap=%0d required 1/0/0",
                         m, n_done, n_strobe_bad, n_overlap);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [38:0] w;
        make_src(1);
        new_words();
        w = pe_cfg_word;
        clear_mon();
        run_pass(2, -1, NROW + 4, ~w, NTAG, 400);
        @(negedge clk);
        checks++;
        if (n_pe != 1 || obs_pe !== w || n_done != 1) begin
            failures++;
            $display("FAIL busy_start pe=%h n_pe=%0d done=%0d required %h/1/1", obs_pe, n_pe, n_done, w);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || pe_config_in !== w) begin
            failures++;
            $display("FAIL busy_start_after busy=%b pe=%h required 0/%h", busy, pe_config_in, w);
        end
    endtask

    task automatic test_reset_mid_pass();
        make_src(1);
        new_words();
        clear_mon();
        run_pass(0, NROW + 10, -1, '0, NTAG, 200);
        @(negedge clk);
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h required=0", all_out);
        end
        make_src(1);
        new_words();
        clear_mon();
        run_pass(0, -1, -1, '0, NTAG, 200);
        @(negedge clk);
        check_stream("midrst_rerun");
        checks++;
        if (n_done != 1 || n_busy != NTAG + 3) begin
            failures++;
            $display("FAIL midrst_rerun done=%0d busy_cycles=%0d required 1/%0d", n_done, n_busy, NTAG + 3);
        end
    endtask

    task automatic test_data_width();
        make_src(2);
        new_words();
        clear_mon();
        run_pass(0, -1, -1, '0, NTAG, 200);
        @(negedge clk);
        checks++;
        if (obs_row.size() != NROW) begin
            failures++;
            $display("FAIL width_len got=%0d required=%0d", obs_row.size(), NROW);
        end
        foreach (obs_row[i]) begin
            checks++;
            if (obs_row[i] !== 4'hf) begin
                failures++;
                $display("FAIL width_row[%0d] got=%h required=f", i, obs_row[i]);
            end
        end
    endtask

    task automatic test_timeout();
        make_src(1);
        new_words();
        clear_mon();
        run_pass(0, -1, -1, '0, 3, 60);
        @(negedge clk);
        checks++;
        if (obs_row.size() != 3 || n_done != 0 || n_pe != 0 || n_ln != 0) begin
            failures++;
            $display("FAIL timeout_stream rows=%0d done=%0d pe=%0d ln=%0d required 3/0/0/0",
                     obs_row.size(), n_done, n_pe, n_ln);
        end
`ifdef CFG_TIMEOUT_EN
        checks++;
        if (n_err != 1 || err_cyc - last_hs_cyc != TOUT || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err n=%0d delay=%0d busy=%b required 1/%0d/0",
                     n_err, err_cyc - last_hs_cyc, busy, TOUT);
        end
`else
        checks++;
        if (n_err != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_wait err=%0d busy=%b required 0/1", n_err, busy);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_recover busy=%b required 0", busy);
        end
`endif
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic_pass();
        test_stall();
        test_start_while_busy();
        test_reset_mid_pass();
        test_data_width();
        test_timeout();
        test_basic_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
